// File: rtl/fifo_write.sv
// Write-side controller for the FIFO loop test: waits for almost_empty to rise,
// settles for DELAY_CYCLES, then bursts an incrementing pattern until almost_full/full.
module fifo_write #(
    parameter int DATA_W       = 8,
    parameter int DELAY_CYCLES = 10,
    parameter int DATA_START   = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              almost_empty,
    input  logic              almost_full,
    input  logic              full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              busy,
    output logic [7:0]        burst_cnt,
    output logic              wr_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [3:0]        DELAY_LIM = 4'(DELAY_CYCLES);
    localparam logic [DATA_W-1:0] DATA_INIT = DATA_W'(DATA_START);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

    state_t            state_q;
    logic [3:0]        delay_cnt_q;
    logic              ae_t0_q;
    logic              ae_t1_q;
    logic              ae_rise;
    logic [DATA_W-1:0] wdata_d;

    assign ae_rise = ae_t0_q & ~ae_t1_q;
    assign wdata_d = fifo_wdata + DATA_ONE;
    assign busy    = (state_q == DELAY) || (state_q == WRITE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            delay_cnt_q <= 4'd0;
            ae_t0_q     <= 1'b0;
            ae_t1_q     <= 1'b0;
            fifo_wr_en  <= 1'b0;
            fifo_wdata  <= DATA_INIT;
            burst_cnt   <= 8'd0;
            wr_overflow <= 1'b0;
        end else begin
            ae_t0_q <= almost_empty;
            ae_t1_q <= ae_t0_q;

            // Data runs on across bursts so the reader can check continuity.
            if (fifo_wr_en) begin
                fifo_wdata <= wdata_d;
            end
            if (fifo_wr_en && full) begin
                wr_overflow <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ae_rise) begin
                        state_q     <= DELAY;
                        delay_cnt_q <= 4'd0;
                    end
                end
                DELAY: begin
                    if (delay_cnt_q == DELAY_LIM) begin
                        state_q     <= WRITE;
                        fifo_wr_en  <= 1'b1;
                        delay_cnt_q <= 4'd0;
                    end else begin
                        delay_cnt_q <= delay_cnt_q + 4'd1;
                    end
                end
                WRITE: begin
                    // The write on the edge that sees the flag still lands.
                    if (almost_full || full) begin
                        fifo_wr_en <= 1'b0;
                        state_q    <= IDLE;
                        burst_cnt  <= burst_cnt + 8'd1;
                    end else begin
                        fifo_wr_en <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    fifo_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_write.md
# fifo_write

Write-side controller for the FIFO test loop; the counterpart of the FIFO reader. It watches the FIFO `almost_empty` flag, waits a settling delay, then bursts an incrementing byte pattern into the FIFO until `almost_full` (or `full`) asserts. The data sequence continues across bursts, so the reader can check continuity end to end. It sits between the FIFO IP write port and the top level, in the same clock domain as the reader.

## Interface
Parameters:
- `DATA_W`, default 8: write data width.
- `DELAY_CYCLES`, default 10: settling cycles spent in DELAY before writing starts. Range 0–15.
- `DATA_START`, default 0: first data value after reset.

Ports:
- `sys_clk`, input, 1: the only clock.
- `sys_rst`, input, 1: reset, synchronous, active-high.
- `almost_empty`, input, 1: FIFO almost-empty flag.
- `almost_full`, input, 1: FIFO almost-full flag.
- `full`, input, 1: FIFO full flag.
- `fifo_wr_en`, output reg, 1: FIFO write enable.
- `fifo_wdata`, output reg, DATA_W: FIFO write data.
- `busy`, output, 1: high while state is DELAY or WRITE.
- `burst_cnt`, output reg, 8: number of completed bursts; wraps from 255 to 0.
- `wr_overflow`, output reg, 1: sticky error flag.

## Operation
- Edge detect:
  - `ae_t0 <= almost_empty` and `ae_t1 <= ae_t0`; both reset to 0.
  - `ae_rise = ae_t0 & ~ae_t1`.
  - A FIFO that is empty at reset release therefore produces a rise.
- State machine (2-bit; reset value IDLE; any unused encoding goes to IDLE):
  - IDLE: if `ae_rise`, go to DELAY and set `delay_cnt = 0`. Otherwise hold.
  - DELAY: if `delay_cnt == DELAY_CYCLES`, go to WRITE, set `fifo_wr_en <= 1` and clear `delay_cnt`. Otherwise increment `delay_cnt` (4 bits).
  - WRITE: if `almost_full | full`, set `fifo_wr_en <= 0` and go to IDLE, incrementing `burst_cnt`. Otherwise keep `fifo_wr_en = 1`.
- Data:
  - On every edge where `fifo_wr_en == 1`, `fifo_wdata <= fifo_wdata + 1`, modulo 2^DATA_W (0xFF wraps to 0x00).
  - `fifo_wdata` is never reloaded except by reset.
- `ae_rise` is only acted on in IDLE. It is ignored in DELAY and WRITE, and `almost_empty` held high never retriggers.
- If IDLE exits on `ae_rise` while `almost_full` is already high, the block still passes through DELAY, performs exactly one write, then returns to IDLE.
- `wr_overflow` is set on any edge where `fifo_wr_en & full`. It is cleared only by reset.
- Reset values: `fifo_wr_en = 0`, `fifo_wdata = DATA_START`, `busy = 0`, `burst_cnt = 0`, `wr_overflow = 0`, state IDLE, `delay_cnt = 0`, `ae_t0 = ae_t1 = 0`.

## Timing
- Reset:
  - `sys_rst` is sampled on the `sys_clk` rising edge.
  - Outputs take their reset values after the first edge with `sys_rst = 1`, including mid-DELAY or mid-WRITE. `fifo_wr_en` is low after that edge.
  - Reset has priority over all other logic.
- Start latency: let `almost_empty` be first sampled high at edge k.
  - `ae_rise` is high between k and k+1.
  - State is DELAY after k+1.
  - `fifo_wr_en` is high after k+DELAY_CYCLES+2 (k+12 at default).
  - With `DELAY_CYCLES = 0`, `fifo_wr_en` is high after k+2.
- First write carries the current `fifo_wdata`: DATA_START after reset, otherwise last burst's final value + 1.
- Stop:
  - `almost_full`/`full` sampled high at edge m while in WRITE: the write at edge m is still issued (`fifo_wr_en` was high), so `fifo_wdata` increments at m.
  - `fifo_wr_en` is low after m; state is IDLE and `burst_cnt` is incremented after m.
  - `busy` is low after m, so exactly one write follows the flag.
- Throughput: one write per cycle while in WRITE, no gaps.
- `busy` is combinational from state, with no added latency.

## Test plan
- Reset check: hold `sys_rst = 1` for 3 cycles with random inputs. Required: `fifo_wr_en = 0`, `fifo_wdata = 0x00`, `busy = 0`, `burst_cnt = 0`, `wr_overflow = 0`.
- First fill: behavioural FIFO (depth 256, `almost_empty` at ≤1, `almost_full` at ≥255) is empty at reset release. Required:
  - `fifo_wr_en` rises 12 edges after `almost_empty` is first sampled.
  - Data is 0x00, 0x01, … consecutive.
  - Writing stops one write after `almost_full`; 256 words are written; `full` never coincides with `fifo_wr_en`; `burst_cnt = 1`; `wr_overflow = 0`.
- Second burst: the reader drains the FIFO until `almost_empty` rises again. Required: the next burst begins with the previous burst's final value + 1 (wrapping 0xFF to 0x00); `burst_cnt = 2`.
- Retrigger immunity: pulse `almost_empty` 0→1→0→1 during DELAY and during WRITE, and hold it high in IDLE. Required: no extra DELAY entry, `burst_cnt` unchanged, write length unchanged.
- Overflow: force `full = 1` during the first WRITE cycle with `almost_full = 0`. Required: `wr_overflow = 1` after that edge and stays 1; `fifo_wr_en` is 0 one edge later; `burst_cnt` increments.
- Reset mid-WRITE: assert `sys_rst` for 1 cycle after 5 writes (data at 0x05). Required: after that edge `fifo_wr_en = 0`, `fifo_wdata = 0x00`, state IDLE; the next `almost_empty` rise restarts with 12-edge latency.
